// File: rtl/audio_pwm_sequencer.sv
// Mixes the two TIA audio channels into one PWM control word, updated only at
// PWM period boundaries, with a linear ramp on enable/disable to avoid pops.
module audio_pwm_sequencer #(
    parameter int unsigned CW_WIDTH  = 10,
    parameter int unsigned CH_WIDTH  = 8,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [CH_WIDTH-1:0] ch0_sample_i,
    input  logic                ch0_valid_i,
    output logic                ch0_ready_o,
    input  logic [CH_WIDTH-1:0] ch1_sample_i,
    input  logic                ch1_valid_i,
    output logic                ch1_ready_o,
    output logic [CW_WIDTH-1:0] pwm_cw_o,
    output logic                period_strobe_o,
    output logic                underrun_o,
    output logic [1:0]          state_o
);

    localparam int unsigned AW = CW_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CW_WIDTH-1:0] cnt_q, cnt_d;
    logic [CW_WIDTH-1:0] pwm_q, pwm_d;
    logic                underrun_q, underrun_d;
    logic                full_q [2];
    logic                full_d [2];
    logic [CH_WIDTH-1:0] hold_q [2];
    logic [CH_WIDTH-1:0] hold_d [2];
    logic [CH_WIDTH-1:0] last_q [2];
    logic [CH_WIDTH-1:0] last_d [2];
    logic [CH_WIDTH-1:0] sample_w [2];
    logic                valid_w [2];
    logic                strobe_w;
    logic [AW-1:0]       target_w;
    logic [AW-1:0]       up_w;

    assign sample_w[0] = ch0_sample_i;
    assign sample_w[1] = ch1_sample_i;
    assign valid_w[0]  = ch0_valid_i;
    assign valid_w[1]  = ch1_valid_i;

    assign strobe_w        = (cnt_q == {CW_WIDTH{1'b1}});
    assign period_strobe_o = strobe_w;
    assign ch0_ready_o     = !full_q[0];
    assign ch1_ready_o     = !full_q[1];
    assign pwm_cw_o        = pwm_q;
    assign underrun_o      = underrun_q;
    assign state_o         = state_q;
    assign cnt_d           = cnt_q + CW_WIDTH'(1);

    // Holding regs: consumed at the boundary; a boundary-cycle transfer lands for the next one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full_d[i] = full_q[i];
            hold_d[i] = hold_q[i];
            last_d[i] = last_q[i];
            if (strobe_w && full_q[i]) begin
                last_d[i] = hold_q[i];
                full_d[i] = 1'b0;
            end
            if (valid_w[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                hold_d[i] = sample_w[i];
            end
        end
        target_w   = (AW'(last_d[0]) + AW'(last_d[1])) << 1;
        up_w       = AW'(pwm_q) + AW'(RAMP_STEP);
        underrun_d = strobe_w && (state_q == RUN) && !(full_q[0] && full_q[1]);
    end

    // Next-state and control word, evaluated only on the boundary cycle.
    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        if (strobe_w) begin
            case (state_q)
                IDLE: begin
                    pwm_d = '0;
                    if (enable_i) state_d = RAMP_UP;
                end
                RAMP_UP: begin
                    if (!enable_i) begin
                        state_d = RAMP_DOWN;
                    end else if (up_w >= target_w) begin
                        pwm_d   = CW_WIDTH'(target_w);
                        state_d = RUN;
                    end else begin
                        pwm_d = CW_WIDTH'(up_w);
                    end
                end
                RUN: begin
                    pwm_d = CW_WIDTH'(target_w);
                    if (!enable_i) state_d = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (enable_i) begin
                        state_d = RAMP_UP;
                    end else if (AW'(pwm_q) <= AW'(RAMP_STEP)) begin
                        pwm_d   = '0;
                        state_d = IDLE;
                    end else begin
                        pwm_d = pwm_q - CW_WIDTH'(RAMP_STEP);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pwm_q      <= '0;
            underrun_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                full_q[i] <= 1'b0;
                hold_q[i] <= '0;
                last_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
            for (int i = 0; i < 2; i++) begin
                full_q[i] <= full_d[i];
                hold_q[i] <= hold_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_sequencer.sv
// Randomized and directed bench for audio_pwm_sequencer against a per-period
// behavioural model of mixing, ramping and the holding-register handshake.
module tb_audio_pwm_sequencer;

    localparam int PERIOD = 1024;
    localparam int STEP   = 4;
    localparam int S_IDLE = 0, S_UP = 1, S_RUN = 2, S_DOWN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] ch0_sample = '0, ch1_sample = '0;
    logic       ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic       ch0_ready, ch1_ready;
    logic [9:0] pwm_cw;
    logic       period_strobe, underrun;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_cnt, m_pwm, m_st, m_last0, m_last1, m_hold0, m_hold1;
    bit m_full0, m_full1, m_under;

    audio_pwm_sequencer dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable),
        .ch0_sample_i(ch0_sample), .ch0_valid_i(ch0_valid), .ch0_ready_o(ch0_ready),
        .ch1_sample_i(ch1_sample), .ch1_valid_i(ch1_valid), .ch1_ready_o(ch1_ready),
        .pwm_cw_o(pwm_cw), .period_strobe_o(period_strobe), .underrun_o(underrun),
        .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: one sample slot per channel, mixing and ramp rules applied per period.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_pwm = 0; m_st = S_IDLE;
            m_full0 = 0; m_full1 = 0; m_hold0 = 0; m_hold1 = 0;
            m_last0 = 0; m_last1 = 0; m_under = 0;
        end else begin
            bit boundary, take0, take1;
            int target;
            boundary = (m_cnt == PERIOD - 1);
            take0 = ch0_valid && !m_full0;
            take1 = ch1_valid && !m_full1;
            m_under = boundary && m_st == S_RUN && (!m_full0 || !m_full1);
            if (boundary) begin
                if (m_full0) begin m_last0 = m_hold0; m_full0 = 0; end
                if (m_full1) begin m_last1 = m_hold1; m_full1 = 0; end
                target = 2 * (m_last0 + m_last1);
                if (m_st == S_IDLE) begin
                    m_pwm = 0;
                    if (enable) m_st = S_UP;
                end else if (m_st == S_UP) begin
                    if (!enable) m_st = S_DOWN;
                    else if (m_pwm + STEP >= target) begin m_pwm = target; m_st = S_RUN; end
                    else m_pwm = m_pwm + STEP;
                end else if (m_st == S_RUN) begin
                    m_pwm = target;
                    if (!enable) m_st = S_DOWN;
                end else begin
                    if (enable) m_st = S_UP;
                    else if (m_pwm <= STEP) begin m_pwm = 0; m_st = S_IDLE; end
                    else m_pwm = m_pwm - STEP;
                end
            end
            if (take0) begin m_full0 = 1; m_hold0 = int'(ch0_sample); end
            if (take1) begin m_full1 = 1; m_hold1 = int'(ch1_sample); end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("pwm_cw", int'(pwm_cw), m_pwm);
        check("state", int'(state), m_st);
        check("ch0_ready", int'(ch0_ready), int'(!m_full0));
        check("ch1_ready", int'(ch1_ready), int'(!m_full1));
        check("period_strobe", int'(period_strobe), int'(m_cnt == PERIOD - 1));
        check("underrun", int'(underrun), int'(m_under));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One full period starting at counter 0; samples offered for one cycle (or held if hold0).
    task automatic period(input bit en, input bit v0, input int s0, input bit v1, input int s1,
                          input bit hold0);
        enable = en;
        ch0_valid = v0; ch0_sample = 8'(s0);
        ch1_valid = v1; ch1_sample = 8'(s1);
        for (int c = 0; c < PERIOD; c++) begin
            step();
            if (c == 0) begin
                if (!hold0) ch0_valid = 1'b0;
                ch1_valid = 1'b0;
            end
        end
        ch0_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) step();
        check("reset_pwm", int'(pwm_cw), 0);
        check("reset_state", int'(state), 0);
        check("reset_ready0", int'(ch0_ready), 1);
        check("reset_ready1", int'(ch1_ready), 1);
        check("reset_strobe", int'(period_strobe), 0);
        reset = 1'b0;

        // Ramp up to target 32: one IDLE boundary, then 4,8,...,32.
        for (int p = 0; p < 5; p++) period(1, 1, 8'h08, 1, 8'h08, 0);
        check("ramp_mid_pwm", int'(pwm_cw), 16);
        check("ramp_mid_state", int'(state), S_UP);
        for (int p = 0; p < 4; p++) period(1, 1, 8'h08, 1, 8'h08, 0);
        check("ramp_end_pwm", int'(pwm_cw), 32);
        check("ramp_end_state", int'(state), S_RUN);

        period(1, 1, 8'hFF, 1, 8'hFF, 0);
        check("full_scale", int'(pwm_cw), 1020);

        // ch1 stops after 0x40: last sample reused, underrun each boundary.
        period(1, 1, 8'h00, 1, 8'h40, 0);
        check("reuse_pwm0", int'(pwm_cw), 128);
        period(1, 1, 8'h00, 0, 0, 0);
        period(1, 1, 8'h00, 0, 0, 0);
        check("reuse_pwm2", int'(pwm_cw), 128);

        // ch0_valid held for a whole period: only one beat per period.
        period(1, 1, 8'h10, 1, 8'h10, 1);
        period(1, 1, 8'h11, 1, 8'h10, 0);

        // Target 10, then ramp down 10,6,2,0.
        period(1, 1, 5, 1, 0, 0);
        check("run10", int'(pwm_cw), 10);
        period(0, 1, 5, 1, 0, 0);
        period(0, 1, 5, 1, 0, 0);
        check("down6", int'(pwm_cw), 6);
        period(0, 1, 5, 1, 0, 0);
        period(0, 1, 5, 1, 0, 0);
        check("down_idle_pwm", int'(pwm_cw), 0);
        check("down_idle_state", int'(state), S_IDLE);
        for (int p = 0; p < 4; p++) period(1, 1, 5, 1, 0, 0);
        check("reramp10", int'(pwm_cw), 10);
        period(0, 1, 5, 1, 0, 0);
        period(0, 1, 5, 1, 0, 0);
        period(1, 1, 5, 1, 0, 0);
        check("reenable_pwm", int'(pwm_cw), 6);
        check("reenable_state", int'(state), S_UP);

        // Randomized traffic, enable and sample values.
        for (int p = 0; p < 20; p++) begin
            enable = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < PERIOD; c++) begin
                ch0_valid = ($urandom_range(0, 300) == 0);
                ch1_valid = ($urandom_range(0, 300) == 0);
                ch0_sample = 8'($urandom);
                ch1_sample = 8'($urandom);
                if ($urandom_range(0, 2000) == 0) enable = ~enable;
                step();
            end
        end
        ch0_valid = 0; ch1_valid = 0;

        // Reset mid-RAMP_UP at counter 500.
        do_reset();
        period(1, 1, 8'h80, 1, 8'h80, 0);
        for (int c = 0; c < 500; c++) step();
        check("pre_reset_state", int'(state), S_UP);
        reset = 1'b1;
        #1;
        check("mid_reset_pwm", int'(pwm_cw), 0);
        check("mid_reset_state", int'(state), 0);
        check("mid_reset_ready0", int'(ch0_ready), 1);
        repeat (2) step();
        reset = 1'b0;
        n = 0;
        while (!period_strobe && n < 2 * PERIOD) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("strobe_after_release", n, PERIOD - 1);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
